alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_issue_if.sv | 46 ++++
 rtl/alu_decode.sv | 56 +++++
 rtl/alu_issue.sv | 107 ++++++++++
 tb/tb_alu_issue.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, opcode/funct values,
// FSM states and the packed records carried between pipeline phases.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] CTRL_ADDU    = 4'b0000;
  localparam logic [3:0] CTRL_ADD     = 4'b0001;
  localparam logic [3:0] CTRL_AND     = 4'b0010;
  localparam logic [3:0] CTRL_OR      = 4'b0011;
  localparam logic [3:0] CTRL_NOT     = 4'b0100;
  localparam logic [3:0] CTRL_NOR     = 4'b0101;
  localparam logic [3:0] CTRL_XOR     = 4'b0110;
  localparam logic [3:0] CTRL_NEG     = 4'b0111;
  localparam logic [3:0] CTRL_SUBU    = 4'b1000;
  localparam logic [3:0] CTRL_SUB     = 4'b1001;
  localparam logic [3:0] CTRL_SLTU    = 4'b1010;
  localparam logic [3:0] CTRL_SLT     = 4'b1011;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation latched at issue; drives the external ALU directly.
  typedef struct packed {
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [3:0]      ctrl;
    logic [4:0]      wreg;
    logic            trap;
    logic            illegal;
  } op_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      wreg;
    logic            exc;
    logic            illegal;
  } wb_t;

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] imm, input logic sext);
    return {{(XLEN-16){sext & imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction, ALU and writeback handshakes around alu_issue.
// slave is the issue stage's view; master is the surrounding pipeline/ALU view.
interface alu_issue_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_opcode;
  logic [5:0]      in_funct;
  logic [15:0]     in_imm;
  logic [XLEN-1:0] in_rs;
  logic [XLEN-1:0] in_rt;
  logic [4:0]      in_wreg;

  logic [XLEN-1:0] alu_rs;
  logic [XLEN-1:0] alu_rt;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_rd;
  logic            alu_overflow;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_wreg;
  logic            out_exc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct, in_imm, in_rs, in_rt, in_wreg,
    output in_ready,
    output alu_rs, alu_rt, alu_ctrl,
    input  alu_rd, alu_overflow,
    output out_valid, out_result, out_wreg, out_exc, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_funct, in_imm, in_rs, in_rt, in_wreg,
    input  in_ready,
    input  alu_rs, alu_rt, alu_ctrl,
    output alu_rd, alu_overflow,
    input  out_valid, out_result, out_wreg, out_exc, out_illegal,
    output out_ready
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational decoder: opcode/funct/imm -> ALU ctrl, extended immediate, use-imm,
// trap-class and illegal flags. Anything not recognised falls through to the illegal code.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0]      i_opcode,
  input  logic [5:0]      i_funct,
  input  logic [15:0]     i_imm,
  output logic [3:0]      o_ctrl,
  output logic [XLEN-1:0] o_ext_imm,
  output logic            o_use_imm,
  output logic            o_trap,
  output logic            o_illegal
);

  logic w_sext;

  always_comb begin
    o_ctrl    = CTRL_ILLEGAL;
    o_use_imm = 1'b0;
    o_trap    = 1'b0;
    o_illegal = 1'b0;
    w_sext    = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  begin o_ctrl = CTRL_ADD; o_trap = 1'b1; end
          FN_ADDU: o_ctrl = CTRL_ADDU;
          FN_SUB:  begin o_ctrl = CTRL_SUB; o_trap = 1'b1; end
          FN_SUBU: o_ctrl = CTRL_SUBU;
          FN_AND:  o_ctrl = CTRL_AND;
          FN_OR:   o_ctrl = CTRL_OR;
          FN_XOR:  o_ctrl = CTRL_XOR;
          FN_NOR:  o_ctrl = CTRL_NOR;
          FN_SLT:  o_ctrl = CTRL_SLT;
          FN_SLTU: o_ctrl = CTRL_SLTU;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_ctrl = CTRL_ADD; o_use_imm = 1'b1; w_sext = 1'b1; o_trap = 1'b1;
      end
      OP_ADDIU: begin o_ctrl = CTRL_ADDU; o_use_imm = 1'b1; w_sext = 1'b1; end
      // sltiu compares against the sign-extended immediate, treated as unsigned
      OP_SLTI:  begin o_ctrl = CTRL_SLT;  o_use_imm = 1'b1; w_sext = 1'b1; end
      OP_SLTIU: begin o_ctrl = CTRL_SLTU; o_use_imm = 1'b1; w_sext = 1'b1; end
      OP_ANDI:  begin o_ctrl = CTRL_AND;  o_use_imm = 1'b1; end
      OP_ORI:   begin o_ctrl = CTRL_OR;   o_use_imm = 1'b1; end
      OP_XORI:  begin o_ctrl = CTRL_XOR;  o_use_imm = 1'b1; end
      default:  o_illegal = 1'b1;
    endcase
  end

  assign o_ext_imm = ext16(i_imm, w_sext);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: latch one instruction, drive the external ALU for a cycle, hold the result until accepted.
// Define ALU_ISSUE_OVF_TRAP_EN to turn overflow on add/sub/addi into an exception with no register write.
module alu_issue
  import alu_pkg::*;
(
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  op_t             r_op;
  wb_t             r_wb;
  logic            w_accept_in;
  logic            w_capture;
  logic            w_ovf_trap;

  logic [3:0]      w_dec_ctrl;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_use_imm;
  logic            w_dec_trap;
  logic            w_dec_illegal;

  alu_decode u_decode (
    .i_opcode  (bus.in_opcode),
    .i_funct   (bus.in_funct),
    .i_imm     (bus.in_imm),
    .o_ctrl    (w_dec_ctrl),
    .o_ext_imm (w_dec_imm),
    .o_use_imm (w_dec_use_imm),
    .o_trap    (w_dec_trap),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake outputs are masked by rst so nothing is offered or accepted in the reset cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept_in   = 1'b0;
    w_capture     = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid) begin
          w_accept_in = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = !rst;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  assign w_ovf_trap = r_op.trap & bus.alu_overflow;
`else
  logic w_unused_ovf;
  assign w_ovf_trap   = 1'b0;
  assign w_unused_ovf = bus.alu_overflow ^ r_op.trap;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      r_wb <= '0;
    end else begin
      if (w_accept_in) begin
        r_op.rs      <= bus.in_rs;
        r_op.rt      <= w_dec_use_imm ? w_dec_imm : bus.in_rt;
        r_op.ctrl    <= w_dec_ctrl;
        r_op.wreg    <= w_dec_illegal ? 5'd0 : bus.in_wreg;
        r_op.trap    <= w_dec_trap;
        r_op.illegal <= w_dec_illegal;
      end
      // A trapped result still carries the wrapped ALU value but never writes a register.
      if (w_capture) begin
        r_wb.result  <= bus.alu_rd;
        r_wb.wreg    <= w_ovf_trap ? 5'd0 : r_op.wreg;
        r_wb.exc     <= w_ovf_trap;
        r_wb.illegal <= r_op.illegal;
      end
    end
  end

  assign bus.alu_rs      = r_op.rs;
  assign bus.alu_rt      = r_op.rt;
  assign bus.alu_ctrl    = r_op.ctrl;
  assign bus.out_result  = r_wb.result;
  assign bus.out_wreg    = r_wb.wreg;
  assign bus.out_exc     = r_wb.exc;
  assign bus.out_illegal = r_wb.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed + small random bench for alu_issue with a behavioural ALU and a result scoreboard.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural external ALU, keyed purely on the ctrl code.
  logic [31:0] a_op, b_op, s_add, s_sub;
  assign a_op  = bus.alu_rs;
  assign b_op  = bus.alu_rt;
  assign s_add = a_op + b_op;
  assign s_sub = a_op - b_op;

  always_comb begin
    bus.alu_rd       = 32'h0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_ctrl)
      4'h0, 4'h1: begin
        bus.alu_rd       = s_add;
        bus.alu_overflow = (a_op[31] == b_op[31]) && (s_add[31] != a_op[31]);
      end
      4'h2: bus.alu_rd = a_op & b_op;
      4'h3: bus.alu_rd = a_op | b_op;
      4'h4: bus.alu_rd = ~a_op;
      4'h5: bus.alu_rd = ~(a_op | b_op);
      4'h6: bus.alu_rd = a_op ^ b_op;
      4'h7: bus.alu_rd = -a_op;
      4'h8, 4'h9: begin
        bus.alu_rd       = s_sub;
        bus.alu_overflow = (a_op[31] != b_op[31]) && (s_sub[31] != a_op[31]);
      end
      4'hA: bus.alu_rd = {31'b0, a_op < b_op};
      4'hB: bus.alu_rd = {31'b0, $signed(a_op) < $signed(b_op)};
      default: bus.alu_rd = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        exc;
    logic        illegal;
    logic [3:0]  ctrl;
    logic [31:0] opb;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] s;
    s = x + y;
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return (x[31] != y[31]) && (d[31] != x[31]);
  endfunction

  // Expected writeback computed per mnemonic, independent of the ALU model above.
  function automatic exp_t ref_model(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [15:0] imm, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [4:0] wreg);
    exp_t e;
    logic [31:0] sx, zx;
    logic trap, ovf;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    e.result = 32'h0; e.ctrl = 4'hF; e.opb = rt; e.illegal = 1'b0;
    e.exc = 1'b0; e.wreg = wreg; trap = 1'b0; ovf = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin e.ctrl = 4'h1; e.result = rs + rt; ovf = add_ovf(rs, rt); trap = 1'b1; end
        6'h21: begin e.ctrl = 4'h0; e.result = rs + rt; end
        6'h22: begin e.ctrl = 4'h9; e.result = rs - rt; ovf = sub_ovf(rs, rt); trap = 1'b1; end
        6'h23: begin e.ctrl = 4'h8; e.result = rs - rt; end
        6'h24: begin e.ctrl = 4'h2; e.result = rs & rt; end
        6'h25: begin e.ctrl = 4'h3; e.result = rs | rt; end
        6'h26: begin e.ctrl = 4'h6; e.result = rs ^ rt; end
        6'h27: begin e.ctrl = 4'h5; e.result = ~(rs | rt); end
        6'h2A: begin e.ctrl = 4'hB; e.result = {31'b0, $signed(rs) < $signed(rt)}; end
        6'h2B: begin e.ctrl = 4'hA; e.result = {31'b0, rs < rt}; end
        default: e.illegal = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h08: begin e.ctrl = 4'h1; e.opb = sx; e.result = rs + sx; ovf = add_ovf(rs, sx); trap = 1'b1; end
        6'h09: begin e.ctrl = 4'h0; e.opb = sx; e.result = rs + sx; end
        6'h0A: begin e.ctrl = 4'hB; e.opb = sx; e.result = {31'b0, $signed(rs) < $signed(sx)}; end
        6'h0B: begin e.ctrl = 4'hA; e.opb = sx; e.result = {31'b0, rs < sx}; end
        6'h0C: begin e.ctrl = 4'h2; e.opb = zx; e.result = rs & zx; end
        6'h0D: begin e.ctrl = 4'h3; e.opb = zx; e.result = rs | zx; end
        6'h0E: begin e.ctrl = 4'h6; e.opb = zx; e.result = rs ^ zx; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (e.illegal) begin
      e.ctrl = 4'hF; e.result = 32'h0; e.wreg = 5'd0;
    end
`ifdef ALU_ISSUE_OVF_TRAP_EN
    if (!e.illegal && trap && ovf) begin
      e.exc = 1'b1; e.wreg = 5'd0;
    end
`else
    if (!e.illegal && trap && ovf) e.exc = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Caller sits at a negedge; returns at the negedge after the result is accepted.
  task automatic run_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] wreg, input int stall);
    exp_t e_exec, e;
    int   waited, hs;
    e_exec = ref_model(opc, fn, imm, rs, rt, wreg);
    sb_q.push_back(e_exec);
    bus.out_ready = (stall == 0);
    waited = 0;
    while (!bus.in_ready && waited < 20) begin @(negedge clk); waited++; end
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_opcode = opc; bus.in_funct = fn; bus.in_imm = imm;
    bus.in_rs = rs; bus.in_rt = rt; bus.in_wreg = wreg;
    hs = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".alu_ctrl"}, bus.alu_ctrl, e_exec.ctrl);
    if (!e_exec.illegal) begin
      chk({tag, ".alu_rs"}, bus.alu_rs, rs);
      chk({tag, ".alu_rt"}, bus.alu_rt, e_exec.opb);
    end
    @(negedge clk);
    waited = 0;
    while (!bus.out_valid && waited < 10) begin @(negedge clk); waited++; end
    chk({tag, ".latency"}, cyc - hs, 2);
    e = sb_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      chk({tag, ".stall_valid"}, bus.out_valid, 1);
      chk({tag, ".stall_result"}, bus.out_result, e.result);
      chk({tag, ".stall_wreg"}, bus.out_wreg, e.wreg);
      chk({tag, ".stall_in_ready"}, bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".result"}, bus.out_result, e.result);
    chk({tag, ".wreg"}, bus.out_wreg, e.wreg);
    chk({tag, ".exc"}, bus.out_exc, e.exc);
    chk({tag, ".illegal"}, bus.out_illegal, e.illegal);
    @(negedge clk);
    chk({tag, ".valid_drop"}, bus.out_valid, 0);
    chk({tag, ".ready_back"}, bus.in_ready, 1);
  endtask

  logic [5:0] tab_op [17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
  logic [5:0] tab_fn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    int k;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_funct = '0; bus.in_imm = '0;
    bus.in_rs = '0; bus.in_rt = '0; bus.in_wreg = '0; bus.out_ready = 1'b1;

    @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_result", bus.out_result, 0);
    chk("rst.out_wreg", bus.out_wreg, 0);
    chk("rst.out_exc", bus.out_exc, 0);
    chk("rst.out_illegal", bus.out_illegal, 0);
    chk("rst.alu_rs", bus.alu_rs, 0);
    chk("rst.alu_rt", bus.alu_rt, 0);
    chk("rst.alu_ctrl", bus.alu_ctrl, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", bus.in_ready, 1);

    run_op("add_ovf",   6'h00, 6'h20, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 5'd5, 0);
    run_op("addiu_neg", 6'h09, 6'h00, 16'hFFFF, 32'h00000010, 32'hDEADBEEF, 5'd3, 0);
    run_op("addiu_ovf", 6'h09, 6'h00, 16'h0001, 32'h7FFFFFFF, 32'h0,        5'd4, 0);
    run_op("ori",       6'h0D, 6'h00, 16'h8001, 32'h12340000, 32'h0,        5'd7, 0);
    run_op("slt",       6'h00, 6'h2A, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 5'd8, 0);
    run_op("sltu",      6'h00, 6'h2B, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 5'd8, 0);
    run_op("sub_ovf",   6'h00, 6'h22, 16'h0000, 32'h80000000, 32'h00000001, 5'd9, 0);
    run_op("subu",      6'h00, 6'h23, 16'h0000, 32'h00000005, 32'h00000007, 5'd10, 0);
    run_op("nor",       6'h00, 6'h27, 16'h0000, 32'hF0F0F0F0, 32'h0000FFFF, 5'd11, 0);
    run_op("addi_ovf",  6'h08, 6'h00, 16'h0001, 32'h7FFFFFFF, 32'h0,        5'd12, 0);
    run_op("addi_neg",  6'h08, 6'h00, 16'hFFFE, 32'h00000005, 32'h0,        5'd13, 0);
    run_op("slti",      6'h0A, 6'h00, 16'hFFFF, 32'h00000000, 32'h0,        5'd14, 0);
    run_op("sltiu",     6'h0B, 6'h00, 16'hFFFF, 32'h00000000, 32'h0,        5'd15, 0);
    run_op("andi",      6'h0C, 6'h00, 16'h8001, 32'hFFFFFFFF, 32'h0,        5'd16, 0);
    run_op("illegal_op",  6'h3F, 6'h20, 16'h1234, 32'h11111111, 32'h22222222, 5'd17, 0);
    run_op("illegal_fn",  6'h00, 6'h00, 16'h0000, 32'h11111111, 32'h22222222, 5'd18, 0);
    run_op("stall_xor",   6'h00, 6'h26, 16'h0000, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd19, 5);

    // Reset while the op is executing must drop it silently.
    bus.in_valid = 1'b1; bus.in_opcode = 6'h00; bus.in_funct = 6'h20;
    bus.in_rs = 32'h1; bus.in_rt = 32'h2; bus.in_wreg = 5'd21;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("exec_rst.ctrl_before", bus.alu_ctrl, 4'h1);
    rst = 1'b1;
    #1 chk("exec_rst.in_ready_in_rst", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("exec_rst.in_ready_after", bus.in_ready, 1);
    chk("exec_rst.alu_ctrl", bus.alu_ctrl, 0);
    chk("exec_rst.alu_rs", bus.alu_rs, 0);
    for (int i = 0; i < 4; i++) begin
      chk("exec_rst.no_valid", bus.out_valid, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 16);
      run_op($sformatf("rnd%0d", i), tab_op[k], (tab_op[k] == 6'h00) ? tab_fn[k] : 6'($urandom),
             16'($urandom), $urandom, $urandom, 5'($urandom), (i % 4 == 3) ? 2 : 0);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
